gray_line_writer: RTL and testbench

Stream sink that accepts converted 24-bit pixels over a valid/ready handshake, packs `PIX_PER_LINE` consecutive pixels into one line word, and writes each completed line into a line-organised `sram` (write port: `i_addr`, `i_write`, `i_data`). It is the write-side counterpart of the line-conversion path: it stores a processed frame back into memory in the same line layout the converter reads. It is armed by `start`, writes exactly `LINES` lines, then reports `done`.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_line_writer_line_packer.sv | 53 +++++
 rtl/gray_line_writer.sv | 118 +++++++++++
 tb/tb_gray_line_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared types and default geometry for the gray line-writer path.
//   state_t      : writer FSM states (IDLE, FILL, WRITE, DONE)
//   PIX_W        : default pixel width in bits
//   PIX_PER_LINE : default pixels packed into one line word
//   LINES        : default lines per frame
//   LINE_W       : width of one packed line word
// ---------------------------------------------------------------------------
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIX_W        = 24;
    localparam int PIX_PER_LINE = 30;
    localparam int LINES        = 20;
    localparam int LINE_W       = PIX_W * PIX_PER_LINE;

endpackage

// File: rtl/gray_line_writer_line_packer.sv
// ---------------------------------------------------------------------------
// line_packer
// Collects PIX_PER_LINE pixels into one line word, first pixel in the LSBs.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : a pixel transfers this cycle
//   clear    : restart the line at pixel 0
//   pix      : incoming pixel
//   word     : line word including the pixel currently presented on pix
//   last     : the current transfer is the final pixel of the line
// ---------------------------------------------------------------------------
module line_packer #(
    parameter int PIX_W        = 24,
    parameter int PIX_PER_LINE = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          clear,
    input  logic [PIX_W-1:0]              pix,
    output logic [PIX_W*PIX_PER_LINE-1:0] word,
    output logic                          last
);

    localparam int CNT_W = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_PER_LINE - 1);

    logic [PIX_W*PIX_PER_LINE-1:0] line_q;
    logic [CNT_W-1:0]              pix_cnt;

    // The presented pixel is merged into its slot ahead of the clock edge, so
    // on the final transfer the top level can capture the complete line in the
    // same edge that accepts the last pixel.
    always_comb begin
        word = line_q;
        word[PIX_W*int'(pix_cnt) +: PIX_W] = pix;
    end

    assign last = load && (pix_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q  <= '0;
            pix_cnt <= '0;
        end else if (clear) begin
            pix_cnt <= '0;
        end else if (load) begin
            line_q  <= word;
            pix_cnt <= last ? '0 : pix_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gray_line_writer.sv
// ---------------------------------------------------------------------------
// gray_line_writer
// Stream sink: packs PIX_PER_LINE pixels per line and stores LINES lines into
// a line-organised SRAM, then reports done until the next start.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : single-cycle arm pulse (honoured in IDLE and DONE only)
//   in_valid  : in_data carries a pixel
//   in_data   : pixel
//   in_ready  : pixel accepted this cycle (registered, high only in FILL)
//   mem_addr  : SRAM line address
//   mem_write : SRAM write strobe (one cycle per line)
//   mem_data  : packed line word
//   busy      : frame in progress
//   done      : frame complete, sticky until the next start
// ---------------------------------------------------------------------------
module gray_line_writer #(
    parameter int PIX_W        = gray_pkg::PIX_W,
    parameter int PIX_PER_LINE = gray_pkg::PIX_PER_LINE,
    parameter int LINES        = gray_pkg::LINES,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [PIX_W-1:0]              in_data,
    output logic                          in_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_write,
    output logic [PIX_W*PIX_PER_LINE-1:0] mem_data,
    output logic                          busy,
    output logic                          done
);

    import gray_pkg::*;

    localparam int LINE_BITS = PIX_W * PIX_PER_LINE;
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(LINES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] line_cnt;
    logic                  load;
    logic                  clear;
    logic                  last;
    logic [LINE_BITS-1:0]  word;

    // in_ready is a registered copy of "state is FILL", so the handshake has
    // no combinational input-to-output path.
    assign load  = in_valid && in_ready;
    assign clear = start && ((state == IDLE) || (state == DONE));

    line_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_LINE (PIX_PER_LINE)
    ) u_packer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (clear),
        .pix   (in_data),
        .word  (word),
        .last  (last)
    );

    // Frame sequencer. All outputs are registered and updated alongside the
    // state so each state's output values appear exactly in that state's
    // cycles; mem_addr/mem_data only change when a line is handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            line_cnt  <= '0;
            in_ready  <= 1'b0;
            mem_addr  <= '0;
            mem_write <= 1'b0;
            mem_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FILL;
                        line_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                FILL: begin
                    if (last) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        mem_write <= 1'b1;
                        mem_addr  <= line_cnt;
                        mem_data  <= word;
                    end
                end
                WRITE: begin
                    mem_write <= 1'b0;
                    if (line_cnt == LAST_LINE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= FILL;
                        line_cnt <= line_cnt + 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_line_writer.sv
// ---------------------------------------------------------------------------
// tb_gray_line_writer
// Self-checking bench for gray_line_writer: a default-geometry instance and a
// small instance (2 pixels/line, 3 lines). Expected line words come from the
// pixel sequence the bench drives, packed first pixel in the LSBs.
// ---------------------------------------------------------------------------
module tb_gray_line_writer;

    localparam int PW  = 24;
    localparam int PPL = 30;
    localparam int LN  = 20;
    localparam int AW  = 5;
    localparam int LW  = PW * PPL;
    localparam int NPX = LN * PPL;

    localparam int S_PPL = 2;
    localparam int S_LN  = 3;
    localparam int S_AW  = 2;
    localparam int S_LW  = PW * S_PPL;

    logic          clk;
    logic          rst;

    logic          start;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [LW-1:0] mem_data;
    logic          busy;
    logic          done;

    logic            s_start;
    logic            s_in_valid;
    logic [PW-1:0]   s_in_data;
    logic            s_in_ready;
    logic [S_AW-1:0] s_mem_addr;
    logic            s_mem_write;
    logic [S_LW-1:0] s_mem_data;
    logic            s_busy;
    logic            s_done;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0]   pix_mem [NPX];
    logic [LW-1:0]   exp_word [LN];
    logic [AW-1:0]   wr_addr_q [$];
    logic [LW-1:0]   wr_data_q [$];
    logic [S_AW-1:0] s_addr_q [$];
    logic [S_LW-1:0] s_data_q [$];

    gray_line_writer #(
        .PIX_W(PW), .PIX_PER_LINE(PPL), .LINES(LN), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_data(mem_data), .busy(busy), .done(done)
    );

    gray_line_writer #(
        .PIX_W(PW), .PIX_PER_LINE(S_PPL), .LINES(S_LN), .ADDR_WIDTH(S_AW)
    ) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
        .in_data(s_in_data), .in_ready(s_in_ready), .mem_addr(s_mem_addr),
        .mem_write(s_mem_write), .mem_data(s_mem_data), .busy(s_busy), .done(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM-side monitors: a write is whatever is on the port when the edge
    // that would capture it arrives.
    always @(posedge clk) begin
        if (mem_write) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
        if (s_mem_write) begin
            s_addr_q.push_back(s_mem_addr);
            s_data_q.push_back(s_mem_data);
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_write, busy, done, mem_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {in_ready, mem_write, busy, done, mem_addr});
        end
        checks++;
        if (mem_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %0h expected 0", mem_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL idle_hold: got %b expected 000", {in_ready, busy, done});
        end
    endtask

    // Runs one frame on the default instance. mode 0: pixel n = n, else random.
    // gap_pct: chance of idling in_valid; noise_pct: chance of a stray start.
    // exp_done >= 0 also checks the FILL-entry-to-done cycle count.
    task automatic run_frame(input string name, input int mode, input int gap_pct,
                             input int noise_pct, input int exp_done);
        int idx;
        int cyc;
        int stall_err;
        bit got_done;
        bit acc;
        for (int n = 0; n < NPX; n++)
            pix_mem[n] = (mode == 0) ? PW'(n) : PW'($urandom);
        for (int l = 0; l < LN; l++)
            for (int k = 0; k < PPL; k++)
                exp_word[l][PW*k +: PW] = pix_mem[l*PPL + k];
        wr_addr_q.delete();
        wr_data_q.delete();

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({in_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL %s_start: got ready/busy/done %b expected 110", name, {in_ready, busy, done});
        end

        idx = 0;
        cyc = 0;
        stall_err = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 5000) begin
            in_valid = (idx < NPX) && ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? pix_mem[idx] : PW'($urandom);
            start    = ($urandom_range(99) < noise_pct);
            if (mem_write === 1'b1 && in_ready !== 1'b0)
                stall_err++;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            cyc++;
            got_done = done;
        end
        in_valid = 1'b0;
        start    = 1'b0;

        checks++;
        if (!got_done) begin
            failures++;
            $display("[TB] FAIL %s_timeout: done not seen after %0d cycles", name, cyc);
        end
        if (exp_done >= 0) begin
            checks++;
            if (cyc != exp_done) begin
                failures++;
                $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", name, cyc, exp_done);
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("[TB] FAIL %s_ready_in_write: got %0d cycles expected 0", name, stall_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_busy_done: got %b expected 0", name, busy);
        end
        checks++;
        if (wr_addr_q.size() != LN) begin
            failures++;
            $display("[TB] FAIL %s_write_count: got %0d expected %0d", name, wr_addr_q.size(), LN);
        end
        for (int l = 0; l < LN && l < wr_addr_q.size(); l++) begin
            checks++;
            if (wr_addr_q[l] !== AW'(l)) begin
                failures++;
                $display("[TB] FAIL %s_addr%0d: got %0d expected %0d", name, l, wr_addr_q[l], l);
            end
            checks++;
            if (wr_data_q[l] !== exp_word[l]) begin
                failures++;
                $display("[TB] FAIL %s_data%0d: got %0h expected %0h", name, l, wr_data_q[l], exp_word[l]);
            end
        end
    endtask

    task automatic test_full_frame;
        run_frame("full", 0, 0, 0, LN * (PPL + 1));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_sticky: got %b expected 1", done);
        end
    endtask

    // start arrives while the previous frame is sitting in DONE.
    task automatic test_back_to_back;
        run_frame("b2b", 1, 0, 0, LN * (PPL + 1));
    endtask

    // Stray starts during FILL/WRITE must not disturb counters or timing.
    task automatic test_start_ignored;
        run_frame("noise", 1, 0, 10, LN * (PPL + 1));
    endtask

    task automatic test_random_gaps;
        run_frame("gaps", 1, 40, 0, -1);
    endtask

    task automatic test_reset_midframe;
        int idx;
        int cyc;
        bit acc;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int n = 0; n < NPX; n++)
            pix_mem[n] = PW'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4*PPL + 15 && cyc < 1000) begin
            in_valid = 1'b1;
            in_data  = pix_mem[idx];
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            cyc++;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, mem_write, busy, done, mem_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_ctrl: got %b expected 0", {in_ready, mem_write, busy, done, mem_addr});
        end
        checks++;
        if (mem_data !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_data: got %0h expected 0", mem_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL midrst_writes: got %0d expected 4", wr_addr_q.size());
        end
        run_frame("after_rst", 1, 0, 0, LN * (PPL + 1));
    endtask

    // Small instance with a bursty source: three words {p1,p0},{p3,p2},{p5,p4}.
    task automatic test_small_gaps;
        logic [PW-1:0]   sp [S_LN*S_PPL];
        logic [S_LW-1:0] sw;
        int idx;
        int cyc;
        bit acc;
        for (int n = 0; n < S_LN*S_PPL; n++)
            sp[n] = PW'($urandom);
        s_addr_q.delete();
        s_data_q.delete();
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (s_done !== 1'b1 && cyc < 300) begin
            s_in_valid = (idx < S_LN*S_PPL) && ($urandom_range(99) >= 50);
            s_in_data  = s_in_valid ? sp[idx] : PW'($urandom);
            acc = s_in_valid && s_in_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
            cyc++;
        end
        s_in_valid = 1'b0;
        checks++;
        if (s_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL small_done: got %b expected 1", s_done);
        end
        checks++;
        if (s_data_q.size() != S_LN) begin
            failures++;
            $display("[TB] FAIL small_write_count: got %0d expected %0d", s_data_q.size(), S_LN);
        end
        for (int l = 0; l < S_LN && l < s_data_q.size(); l++) begin
            sw = {sp[2*l + 1], sp[2*l]};
            checks++;
            if (s_data_q[l] !== sw || s_addr_q[l] !== S_AW'(l)) begin
                failures++;
                $display("[TB] FAIL small_line%0d: got addr %0d data %0h expected addr %0d data %0h",
                         l, s_addr_q[l], s_data_q[l], l, sw);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;

        test_reset();
        test_full_frame();
        test_back_to_back();
        test_start_ignored();
        test_random_gaps();
        test_reset_midframe();
        test_small_gaps();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
